// File: rtl/reg_wr_sched_if.sv
// rtl/reg_wr_sched_if.sv - writeback request and register-file write port bundle
interface reg_wr_sched_if #(
    parameter int pw = 3
);
    logic          a_valid;
    logic [pw-1:0] a_addr;
    logic [7:0]    a_data;
    logic          a_ready;
    logic          b_valid;
    logic [pw-1:0] b_addr;
    logic [7:0]    b_data;
    logic          b_ready;
    logic          wr_en;
    logic [pw-1:0] wr_addr;
    logic [7:0]    dat_out;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, wr_en, wr_addr, dat_out
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, wr_en, wr_addr, dat_out
    );
endinterface

// File: rtl/reg_wr_sched.sv
// rtl/reg_wr_sched.sv - round-robin register-file write port scheduler with pending-write scoreboard
module reg_wr_sched #(
    parameter int pw = 3
) (
    input  logic               clk,
    input  logic               reset,
    reg_wr_sched_if.slave      bus,
    input  logic               rsv_en,
    input  logic [pw-1:0]      rsv_addr,
    input  logic               flush,
    output logic [2**pw-1:0]   busy,
    output logic               rsv_err
);
    typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_t;

    rr_t rr_q, rr_d;
    logic contended;
    logic commit_hits_rsv;

    assign contended = bus.a_valid && bus.b_valid && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= RR_A;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Pointer only moves after a contended grant so the loser is served next cycle.
    always_comb begin
        rr_d = rr_q;
        if (flush) begin
            rr_d = RR_A;
        end else if (contended) begin
            rr_d = (rr_q == RR_A) ? RR_B : RR_A;
        end
    end

    always_comb begin
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        if (!flush) begin
            bus.a_ready = bus.a_valid && (!bus.b_valid || rr_q == RR_A);
            bus.b_ready = bus.b_valid && (!bus.a_valid || rr_q == RR_B);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.dat_out <= 8'h00;
        end else begin
            bus.wr_en <= bus.a_ready || bus.b_ready;
            if (bus.a_ready) begin
                bus.wr_addr <= bus.a_addr;
                bus.dat_out <= bus.a_data;
            end else if (bus.b_ready) begin
                bus.wr_addr <= bus.b_addr;
                bus.dat_out <= bus.b_data;
            end
        end
    end

    assign commit_hits_rsv = bus.wr_en && (bus.wr_addr == rsv_addr);

    // Reserve is applied after the commit clear so a same-register reserve wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= '0;
            rsv_err <= 1'b0;
        end else if (flush) begin
            busy    <= '0;
            rsv_err <= 1'b0;
        end else begin
            for (int i = 0; i < 2**pw; i++) begin
                if (rsv_en && rsv_addr == i[pw-1:0]) begin
                    busy[i] <= 1'b1;
                end else if (bus.wr_en && bus.wr_addr == i[pw-1:0]) begin
                    busy[i] <= 1'b0;
                end
            end
            if (rsv_en && busy[rsv_addr] && !commit_hits_rsv) begin
                rsv_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_wr_sched.sv
// tb/tb_reg_wr_sched.sv - directed self-checking bench for reg_wr_sched
module tb_reg_wr_sched;
    localparam int pw = 3;

    logic         clk;
    logic         reset;
    logic         rsv_en;
    logic [pw-1:0] rsv_addr;
    logic         flush;
    logic [7:0]   busy;
    logic         rsv_err;
    int           tests;
    int           fails;

    reg_wr_sched_if #(.pw(pw)) bus ();

    reg_wr_sched #(.pw(pw)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy     (busy),
        .rsv_err  (rsv_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
        tests++; if (bus.wr_addr !== 3'd0) begin fails++; $display("FAIL reset_wr_addr got %0d want 0", bus.wr_addr); end
        tests++; if (bus.dat_out !== 8'h00) begin fails++; $display("FAIL reset_dat_out got %h want 00", bus.dat_out); end
        tests++; if (busy !== 8'h00) begin fails++; $display("FAIL reset_busy got %h want 00", busy); end
        tests++; if (rsv_err !== 1'b0) begin fails++; $display("FAIL reset_rsv_err got %b want 0", rsv_err); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bus.a_valid = 1'b1; bus.a_addr = 3'd3; bus.a_data = 8'h5A;
        #1;
        tests++; if (bus.a_ready !== 1'b1) begin fails++; $display("FAIL single_a_ready got %b want 1", bus.a_ready); end
        tests++; if (bus.b_ready !== 1'b0) begin fails++; $display("FAIL single_b_ready got %b want 0", bus.b_ready); end
        @(negedge clk);
        bus.a_valid = 1'b0;
        tests++; if ({bus.wr_en, bus.wr_addr, bus.dat_out} !== {1'b1, 3'd3, 8'h5A}) begin
            fails++; $display("FAIL single_write got en=%b addr=%0d data=%h want en=1 addr=3 data=5a", bus.wr_en, bus.wr_addr, bus.dat_out);
        end
        @(negedge clk);
        tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL single_idle_en got %b want 0", bus.wr_en); end
        tests++; if (bus.wr_addr !== 3'd3 || bus.dat_out !== 8'h5A) begin
            fails++; $display("FAIL single_hold got addr=%0d data=%h want addr=3 data=5a", bus.wr_addr, bus.dat_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_a;
        exp_a = 4'b0101;
        bus.a_valid = 1'b1; bus.a_addr = 3'd1; bus.a_data = 8'h11;
        bus.b_valid = 1'b1; bus.b_addr = 3'd2; bus.b_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (bus.a_ready !== exp_a[i] || bus.b_ready !== !exp_a[i]) begin
                fails++; $display("FAIL b2b_grant%0d got a=%b b=%b want a=%b b=%b", i, bus.a_ready, bus.b_ready, exp_a[i], !exp_a[i]);
            end
            @(negedge clk);
            if (i == 3) begin bus.a_valid = 1'b0; bus.b_valid = 1'b0; end
            tests++; if ({bus.wr_en, bus.wr_addr, bus.dat_out} !== (exp_a[i] ? {1'b1, 3'd1, 8'h11} : {1'b1, 3'd2, 8'h22})) begin
                fails++; $display("FAIL b2b_write%0d got en=%b addr=%0d data=%h", i, bus.wr_en, bus.wr_addr, bus.dat_out);
            end
        end
        @(negedge clk);
        tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL b2b_end_en got %b want 0", bus.wr_en); end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 3'd5;
        @(negedge clk);
        rsv_en = 1'b0;
        tests++; if (busy !== 8'b0010_0000) begin fails++; $display("FAIL sb_reserve got %b want 00100000", busy); end
        bus.b_valid = 1'b1; bus.b_addr = 3'd5; bus.b_data = 8'h55;
        #1;
        tests++; if (bus.b_ready !== 1'b1) begin fails++; $display("FAIL sb_b_ready got %b want 1", bus.b_ready); end
        @(negedge clk);
        bus.b_valid = 1'b0;
        tests++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd5 || busy !== 8'h20) begin
            fails++; $display("FAIL sb_commit got en=%b addr=%0d busy=%h want en=1 addr=5 busy=20", bus.wr_en, bus.wr_addr, busy);
        end
        @(negedge clk);
        tests++; if (busy !== 8'h00) begin fails++; $display("FAIL sb_clear got %h want 00", busy); end
    endtask

    task automatic test_set_wins();
        bus.a_valid = 1'b1; bus.a_addr = 3'd6; bus.a_data = 8'h66;
        @(negedge clk);
        bus.a_valid = 1'b0;
        rsv_en = 1'b1; rsv_addr = 3'd6;
        @(negedge clk);
        rsv_en = 1'b0;
        tests++; if (busy !== 8'h40 || rsv_err !== 1'b0) begin
            fails++; $display("FAIL set_wins got busy=%h err=%b want busy=40 err=0", busy, rsv_err);
        end
    endtask

    task automatic test_rsv_err_flush();
        rsv_en = 1'b1; rsv_addr = 3'd4;
        bus.a_valid = 1'b1; bus.a_addr = 3'd0; bus.a_data = 8'hA0;
        bus.b_valid = 1'b1; bus.b_addr = 3'd1; bus.b_data = 8'hB1;
        @(negedge clk);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(negedge clk);
        rsv_en = 1'b0;
        tests++; if (rsv_err !== 1'b1 || busy !== 8'h50) begin
            fails++; $display("FAIL rsv_err_set got err=%b busy=%h want err=1 busy=50", rsv_err, busy);
        end
        @(negedge clk);
        tests++; if (rsv_err !== 1'b1) begin fails++; $display("FAIL rsv_err_sticky got %b want 1", rsv_err); end
        flush = 1'b1;
        bus.a_valid = 1'b1; bus.a_addr = 3'd2; bus.a_data = 8'hC2;
        #1;
        tests++; if (bus.a_ready !== 1'b0) begin fails++; $display("FAIL flush_no_grant got %b want 0", bus.a_ready); end
        @(negedge clk);
        flush = 1'b0;
        bus.a_valid = 1'b0;
        tests++; if (busy !== 8'h00 || rsv_err !== 1'b0 || bus.wr_en !== 1'b0) begin
            fails++; $display("FAIL flush_clear got busy=%h err=%b en=%b want 00 0 0", busy, rsv_err, bus.wr_en);
        end
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        #1;
        tests++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            fails++; $display("FAIL flush_rr_a got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready);
        end
        @(negedge clk);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) begin
            rsv_en = 1'b1; rsv_addr = i[2:0];
            if (i == 7) begin bus.a_valid = 1'b1; bus.a_addr = 3'd7; bus.a_data = 8'h77; end
            @(negedge clk);
        end
        rsv_en = 1'b0; bus.a_valid = 1'b0;
        tests++; if (busy !== 8'hFF || bus.wr_en !== 1'b1) begin
            fails++; $display("FAIL areset_pre got busy=%h en=%b want FF 1", busy, bus.wr_en);
        end
        #2 reset = 1'b1;
        #1;
        tests++; if (busy !== 8'h00 || bus.wr_en !== 1'b0 || bus.wr_addr !== 3'd0 || bus.dat_out !== 8'h00 || rsv_err !== 1'b0) begin
            fails++; $display("FAIL areset_now got busy=%h en=%b addr=%0d data=%h err=%b want all 0", busy, bus.wr_en, bus.wr_addr, bus.dat_out, rsv_err);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = 8'h00;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_scoreboard();
        test_set_wins();
        test_rsv_err_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
